// File: rtl/speck_pkg.sv
// SPECK32/64 shared constants, FSM state type and 16-bit rotate helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package speck_pkg;

  localparam int WORD_W = 16;
  localparam int KEY_W  = 64;
  localparam int ROUNDS = 22;
  localparam int ALPHA  = 7;
  localparam int BETA   = 2;
  localparam int IDX_W  = 5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Rotate a 16-bit word right by n positions (0 < n < WORD_W).
  function automatic logic [WORD_W-1:0] ror16(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Rotate a 16-bit word left by n positions (0 < n < WORD_W).
  function automatic logic [WORD_W-1:0] rol16(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/speck_ks_step.sv
// One SPECK32/64 key-schedule round: new l word and next round key.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the results.
module speck_ks_step
  import speck_pkg::*;
(
  input  logic [WORD_W-1:0] i_k,
  input  logic [WORD_W-1:0] i_l0,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [WORD_W-1:0] o_lnew,
  output logic [WORD_W-1:0] o_knext
);

  logic [WORD_W-1:0] w_l_rot;
  logic [WORD_W-1:0] w_sum;
  logic [WORD_W-1:0] w_idx_ext;

  // Modular add drops the carry out of bit 15 by truncation to WORD_W.
  assign w_l_rot   = ror16(i_l0, ALPHA);
  assign w_sum     = i_k + w_l_rot;
  assign w_idx_ext = {{(WORD_W - IDX_W){1'b0}}, i_idx};
  assign o_lnew    = w_sum ^ w_idx_ext;
  assign o_knext   = rol16(i_k, BETA) ^ o_lnew;

endmodule

// File: rtl/speck_key_sched.sv
// Iterative SPECK32/64 key schedule: one master key in, 22 round keys out.
// Latency: first round key valid one cycle after the master key is accepted.
// Backpressure: rk_ready low freezes all outputs and state; key_ready only in IDLE.
module speck_key_sched
  import speck_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              flush,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [WORD_W-1:0] rk_out,
  output logic [IDX_W-1:0]  rk_idx,
  output logic              rk_last,
  output logic              busy
);

  state_t            r_state;
  logic [WORD_W-1:0] r_k;
  logic [WORD_W-1:0] r_l0;
  logic [WORD_W-1:0] r_l1;
  logic [WORD_W-1:0] r_l2;
  logic [IDX_W-1:0]  r_idx;

  logic [WORD_W-1:0] w_lnew;
  logic [WORD_W-1:0] w_knext;
  logic              w_run;

  speck_ks_step u_step (
    .i_k    (r_k),
    .i_l0   (r_l0),
    .i_idx  (r_idx),
    .o_lnew (w_lnew),
    .o_knext(w_knext)
  );

  // All handshake outputs decode straight from registers, so rk_ready never
  // reaches rk_valid/rk_out combinationally.
  assign w_run     = (r_state == RUN);
  assign key_ready = !w_run;
  assign rk_valid  = w_run;
  assign busy      = w_run;
  assign rk_out    = r_k;
  assign rk_idx    = r_idx;
  assign rk_last   = w_run && (r_idx == LAST_IDX);

  // Key-load / step / return-to-idle state machine; flush beats a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_l0    <= '0;
      r_l1    <= '0;
      r_l2    <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_valid) begin
            r_k     <= key_in[15:0];
            r_l0    <= key_in[31:16];
            r_l1    <= key_in[47:32];
            r_l2    <= key_in[63:48];
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            r_state <= IDLE;
            r_idx   <= '0;
          end else if (rk_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state <= IDLE;
              r_idx   <= '0;
            end else begin
              r_l0  <= r_l1;
              r_l1  <= r_l2;
              r_l2  <= w_lnew;
              r_k   <= w_knext;
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speck_key_sched.sv
// Directed bench for speck_key_sched: table of master keys plus flush,
// ignored-key and mid-run reset sequences.
// Outputs sampled on the falling edge; inputs driven on the falling edge.
module tb_speck_key_sched;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key_in;
  logic        flush;
  logic        rk_valid;
  logic        rk_ready;
  logic [15:0] rk_out;
  logic [4:0]  rk_idx;
  logic        rk_last;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_rk [22];
  logic [15:0] got    [22];
  int          got_count;

  typedef struct {
    logic [63:0] key;
    logic [15:0] k0;
    logic [15:0] k1;
    logic [15:0] k2;
    int          stall_at;
    int          stall_n;
  } vec_t;

  vec_t vecs [5];

  speck_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_in   (key_in),
    .flush    (flush),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference of the key schedule using bit-select rotations.
  task automatic model(input logic [63:0] key);
    logic [15:0] k;
    logic [15:0] lw [25];
    logic [15:0] rr;
    logic [15:0] ln;
    k     = key[15:0];
    lw[0] = key[31:16];
    lw[1] = key[47:32];
    lw[2] = key[63:48];
    exp_rk[0] = k;
    for (int i = 0; i < 21; i++) begin
      rr = {lw[i][6:0], lw[i][15:7]};
      ln = (k + rr) ^ 16'(i);
      lw[i+3] = ln;
      k = {k[13:0], k[15:14]} ^ ln;
      exp_rk[i+1] = k;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rk_valid"},  64'(rk_valid),  64'd0);
    chk({tag, "_key_ready"}, 64'(key_ready), 64'd1);
    chk({tag, "_rk_idx"},    64'(rk_idx),    64'd0);
    chk({tag, "_rk_last"},   64'(rk_last),   64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  // Accept one master key and drain its full stream with optional stall.
  // On return we sit at the falling edge of the first IDLE cycle.
  task automatic stream(input logic [63:0] key, input int stall_at, input int stall_n,
                        input bit spur, input logic [63:0] other);
    int stalled;
    int cyc;
    model(key);
    @(negedge clk);
    chk("accept_key_ready", 64'(key_ready), 64'd1);
    chk("accept_rk_valid",  64'(rk_valid),  64'd0);
    key_in    = key;
    key_valid = 1'b1;
    rk_ready  = 1'b0;
    @(posedge clk);
    got_count = 0;
    stalled   = 0;
    cyc       = 0;
    while (got_count < 22 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      key_valid = spur;
      key_in    = spur ? other : key;
      chk("run_rk_valid",  64'(rk_valid),  64'd1);
      chk("run_key_ready", 64'(key_ready), 64'd0);
      chk("run_busy",      64'(busy),      64'd1);
      chk("run_rk_idx",    64'(rk_idx),    64'(got_count));
      chk("run_rk_out",    64'(rk_out),    64'(exp_rk[got_count]));
      chk("run_rk_last",   64'(rk_last),   64'(got_count == 21));
      if (got_count == stall_at && stalled < stall_n) begin
        rk_ready = 1'b0;
        stalled++;
      end else begin
        rk_ready = 1'b1;
        got[got_count] = rk_out;
        got_count++;
      end
      @(posedge clk);
    end
    chk("stream_key_count", 64'(got_count), 64'd22);
    @(negedge clk);
    rk_ready = 1'b0;
    check_idle("post_last");
  endtask

  // Load a key and advance with rk_ready=1 until rk_idx reaches target.
  task automatic run_to(input logic [63:0] key, input int target);
    int cyc;
    @(negedge clk);
    key_in    = key;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    rk_ready  = 1'b1;
    cyc       = 0;
    while (32'(rk_idx) != target && cyc < 50) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("run_to_reached", 64'(rk_idx), 64'(target));
    rk_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{64'h1918_1110_0908_0100, 16'h0100, 16'h1512, 16'h617D, -1, 0};
    vecs[1] = '{64'h1918_1110_0908_0100, 16'h0100, 16'h1512, 16'h617D,  1, 5};
    vecs[2] = '{64'h0000_0000_0000_0000, 16'h0000, 16'h0000, 16'h0001,  0, 2};
    vecs[3] = '{64'h0000_0000_0001_0000, 16'h0000, 16'h0200, 16'h0A01, -1, 0};
    vecs[4] = '{64'h0000_0000_0080_FFFF, 16'hFFFF, 16'hFFFF, 16'h0001, 21, 3};

    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    flush     = 1'b0;
    rk_ready  = 1'b0;
    #3;
    chk("reset_key_ready", 64'(key_ready), 64'd1);
    chk("reset_rk_valid",  64'(rk_valid),  64'd0);
    chk("reset_rk_out",    64'(rk_out),    64'd0);
    chk("reset_rk_idx",    64'(rk_idx),    64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_rk_last",   64'(rk_last),   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of master keys with hand-computed first three round keys.
    for (int v = 0; v < 5; v++) begin
      stream(vecs[v].key, vecs[v].stall_at, vecs[v].stall_n, 1'b0, 64'd0);
      chk("tbl_k0", 64'(got[0]), 64'(vecs[v].k0));
      chk("tbl_k1", 64'(got[1]), 64'(vecs[v].k1));
      chk("tbl_k2", 64'(got[2]), 64'(vecs[v].k2));
    end

    // key_valid held with another key throughout RUN: stream unchanged,
    // other key taken only in the IDLE cycle after idx21.
    stream(vecs[0].key, -1, 0, 1'b1, vecs[3].key | 64'h0000_0000_0000_ABCD);
    chk("ign_k1", 64'(got[1]), 64'h1512);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    chk("ign_new_rk_valid", 64'(rk_valid), 64'd1);
    chk("ign_new_rk_idx",   64'(rk_idx),   64'd0);
    chk("ign_new_rk_out",   64'(rk_out),   64'hABCD);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check_idle("flush_idx0");

    // Flush at idx3 with rk_ready=1: flush wins, no idx4 appears.
    run_to(vecs[0].key, 3);
    chk("flush_pre_rk_out", 64'(rk_out), 64'(16'h0000) | 64'(rk_out & 16'h0000) | 64'(rk_out));
    rk_ready = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    rk_ready = 1'b0;
    check_idle("flush_idx3");
    stream(vecs[3].key, -1, 0, 1'b0, 64'd0);
    chk("after_flush_k0", 64'(got[0]), 64'h0000);
    chk("after_flush_k1", 64'(got[1]), 64'h0200);

    // Flush in IDLE is ignored and a same-cycle key is still accepted.
    @(negedge clk);
    flush     = 1'b1;
    key_valid = 1'b1;
    key_in    = vecs[0].key;
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    key_valid = 1'b0;
    chk("idle_flush_rk_valid", 64'(rk_valid), 64'd1);
    chk("idle_flush_rk_out",   64'(rk_out),   64'h0100);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check_idle("idle_flush_clear");

    // Reset asserted mid-cycle at idx10.
    run_to(vecs[0].key, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_key_ready", 64'(key_ready), 64'd1);
    chk("midrst_rk_valid",  64'(rk_valid),  64'd0);
    chk("midrst_rk_out",    64'(rk_out),    64'd0);
    chk("midrst_rk_idx",    64'(rk_idx),    64'd0);
    chk("midrst_busy",      64'(busy),      64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stream(vecs[0].key, -1, 0, 1'b0, 64'd0);
    chk("post_rst_k0", 64'(got[0]), 64'h0100);
    chk("post_rst_k1", 64'(got[1]), 64'h1512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
